// File: rtl/hist_pkg.sv
// Shared constants and types for the histogram CDF reader.
// Sizes follow the 8-lane, 256-bin histogram memory.
package hist_pkg;

    localparam int LANES  = 8;
    localparam int BINS   = 256;
    localparam int BIN_W  = 16;
    localparam int ADDR_W = 16;
    localparam int CDF_W  = 24;
    localparam int BEATS  = BINS / LANES;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LANE_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } cdf_state_t;

    typedef logic [CDF_W-1:0] cdf_t;

endpackage

// File: rtl/hist_cdf_reader_lane_prefix_adder.sv
// Combinational inclusive prefix sum across one beat of bins,
// offset by the running CDF base, plus the beat's own total.
module lane_prefix_adder
    import hist_pkg::*;
(
    input  logic [LANES*BIN_W-1:0] vals,
    input  cdf_t                   base,
    output logic [LANES*CDF_W-1:0] sums,
    output cdf_t                   lane_total
);

    cdf_t acc;
    cdf_t tot;

    always_comb begin
        acc  = base;
        tot  = '0;
        sums = '0;
        for (int i = 0; i < LANES; i++) begin
            acc = acc + CDF_W'(vals[i*BIN_W +: BIN_W]);
            tot = tot + CDF_W'(vals[i*BIN_W +: BIN_W]);
            sums[i*CDF_W +: CDF_W] = acc;
        end
        lane_total = tot;
    end

endmodule

// File: rtl/hist_cdf_reader.sv
// Sweeps the histogram 8 bins per beat and streams the running CDF
// over valid/ready, reporting the frame total when the sweep ends.
module hist_cdf_reader
    import hist_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic [LANES*ADDR_W-1:0] hist_addr,
    input  logic [LANES*BIN_W-1:0]  hist_rd,
    output logic                    hist_lock,
    output logic [LANES*CDF_W-1:0]  out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output cdf_t                    total,
    output logic                    done
);

    cdf_state_t              state;
    logic [BEAT_W-1:0]       k;
    cdf_t                    running;
    logic [LANES*CDF_W-1:0]  sums;
    cdf_t                    lane_total;
    logic                    load;
    logic                    accept;
    logic                    last_k;

    lane_prefix_adder u_prefix (
        .vals       (hist_rd),
        .base       (running),
        .sums       (sums),
        .lane_total (lane_total)
    );

    assign load      = (state == SWEEP) && (!out_valid || out_ready);
    assign accept    = out_valid && out_ready;
    assign last_k    = (k == BEAT_W'(BEATS - 1));
    assign hist_lock = (state != IDLE);

    // Address only k; k holds during a stall, so the read stays stable.
    always_comb begin
        hist_addr = '0;
        if (state == SWEEP) begin
            for (int i = 0; i < LANES; i++) begin
                hist_addr[i*ADDR_W +: ADDR_W] = ADDR_W'({k, LANE_W'(i)});
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            running   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            total     <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= SWEEP;
                        k       <= '0;
                        running <= '0;
                        total   <= '0;
                    end
                end
                SWEEP: begin
                    if (load) begin
                        out_data  <= sums;
                        running   <= running + lane_total;
                        out_valid <= 1'b1;
                        out_last  <= last_k;
                        k         <= k + 1'b1;
                        if (last_k) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        total     <= running;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hist_cdf_reader.sv
// Scoreboard bench for hist_cdf_reader with a behavioural
// 256x16 histogram memory and closed-form expected CDFs.
module tb_hist_cdf_reader;
    import hist_pkg::*;

    localparam int DW = LANES * CDF_W;
    localparam int LIMIT = 400;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    out_ready = 1'b0;
    logic [LANES*ADDR_W-1:0] hist_addr;
    logic [LANES*BIN_W-1:0]  hist_rd;
    logic                    hist_lock;
    logic [DW-1:0]           out_data;
    logic                    out_valid;
    logic                    out_last;
    cdf_t                    total;
    logic                    done;

    hist_cdf_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hist_addr (hist_addr),
        .hist_rd   (hist_rd),
        .hist_lock (hist_lock),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .total     (total),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [BIN_W-1:0] mem [BINS];

    always_comb begin
        hist_rd = '0;
        for (int i = 0; i < LANES; i++) begin
            hist_rd[i*BIN_W +: BIN_W] = mem[hist_addr[i*ADDR_W +: 8]];
        end
    end

    int    n_checks = 0;
    int    n_fails = 0;
    int    cyc = 0;
    int    accepts = 0;
    int    done_cnt = 0;
    int    exp_done = 0;
    bit    rnd_ready = 1'b0;
    beat_t exp_q[$];
    cdf_t  tot_q[$];
    int    acc_cyc[$];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops expectations on each accepted beat and done pulse.
    logic                    stall_prev = 1'b0;
    logic [DW-1:0]           prev_data;
    logic [LANES*ADDR_W-1:0] prev_addr;

    always @(negedge clk) begin
        beat_t e;
        cdf_t  t;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_data", out_data, prev_data);
                chk("stall_addr", DW'(hist_addr), DW'(prev_addr));
                chk("stall_valid", DW'(out_valid), DW'(1));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", DW'(1), DW'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e.data);
                    chk("beat_last", DW'(out_last), DW'(e.last));
                end
                accepts++;
                acc_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                if (tot_q.size() == 0) begin
                    chk("unexpected_done", DW'(1), DW'(0));
                end else begin
                    t = tot_q.pop_front();
                    chk("total", DW'(total), DW'(t));
                end
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = hist_addr;
        end
    end

    task automatic push_scaled(input int scale);
        beat_t b;
        for (int k = 0; k < BEATS; k++) begin
            for (int i = 0; i < LANES; i++) begin
                b.data[i*CDF_W +: CDF_W] = CDF_W'((8 * k + i + 1) * scale);
            end
            b.last = (k == BEATS - 1);
            exp_q.push_back(b);
        end
        tot_q.push_back(CDF_W'(256 * scale));
    endtask

    // mem[j] = j gives CDF(n) = n(n+1)/2.
    task automatic push_tri();
        beat_t b;
        int    n;
        for (int k = 0; k < BEATS; k++) begin
            for (int i = 0; i < LANES; i++) begin
                n = 8 * k + i;
                b.data[i*CDF_W +: CDF_W] = CDF_W'(n * (n + 1) / 2);
            end
            b.last = (k == BEATS - 1);
            exp_q.push_back(b);
        end
        tot_q.push_back(24'd32640);
    endtask

    task automatic do_start();
        @(negedge clk);
        chk("lock_idle", DW'(hist_lock), DW'(0));
        acc_cyc.delete();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("lock_sweep", DW'(hist_lock), DW'(1));
        chk("first_valid_lo", DW'(out_valid), DW'(0));
        chk("first_addr_l7", DW'(hist_addr[7*ADDR_W +: ADDR_W]), DW'(7));
        @(negedge clk);
        chk("first_valid_hi", DW'(out_valid), DW'(1));
    endtask

    task automatic wait_accepts(input int base, input int n);
        int c = 0;
        while ((accepts - base) < n && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        if (c >= LIMIT) chk("accept_timeout", DW'(1), DW'(0));
    endtask

    task automatic wait_done(input cdf_t hand_total);
        int c = 0;
        while (!done && c < LIMIT) begin
            @(negedge clk);
            c++;
        end
        if (c >= LIMIT) begin
            chk("done_timeout", DW'(1), DW'(0));
        end else begin
            exp_done++;
            chk("total_hand", DW'(total), DW'(hand_total));
            chk("lock_done", DW'(hist_lock), DW'(1));
            chk("addr_done", DW'(hist_addr), DW'(0));
            @(negedge clk);
            chk("lock_after", DW'(hist_lock), DW'(0));
            chk("done_pulse", DW'(done), DW'(0));
            chk("total_held", DW'(total), DW'(hand_total));
            chk("beats_left", DW'(exp_q.size()), DW'(0));
            chk("done_count", DW'(done_cnt), DW'(exp_done));
        end
    endtask

    initial begin
        int base;
        for (int j = 0; j < BINS; j++) mem[j] = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", DW'(out_valid), DW'(0));
        chk("rst_data", out_data, DW'(0));
        chk("rst_lock", DW'(hist_lock), DW'(0));
        chk("rst_addr", DW'(hist_addr), DW'(0));
        chk("rst_done_total", DW'({done, out_last, total}), DW'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: all zeros, consecutive beats
        push_scaled(0);
        base = accepts;
        do_start();
        wait_done(24'd0);
        chk("t1_accepts", DW'(accepts - base), DW'(32));
        if (acc_cyc.size() == 32) begin
            chk("t1_back2back", DW'(acc_cyc[31] - acc_cyc[0]), DW'(31));
        end else begin
            chk("t1_acc_cnt", DW'(acc_cyc.size()), DW'(32));
        end

        // 2: all ones
        for (int j = 0; j < BINS; j++) mem[j] = 16'd1;
        push_scaled(1);
        base = accepts;
        do_start();
        wait_done(24'd256);
        chk("t2_accepts", DW'(accepts - base), DW'(32));

        // 3: all 0xFFFF, no wrap
        for (int j = 0; j < BINS; j++) mem[j] = 16'hFFFF;
        push_scaled(32'hFFFF);
        do_start();
        wait_done(24'hFFFF00);

        // 4: ones with random backpressure
        for (int j = 0; j < BINS; j++) mem[j] = 16'd1;
        rnd_ready = 1'b1;
        push_scaled(1);
        base = accepts;
        do_start();
        wait_done(24'd256);
        chk("t4_accepts", DW'(accepts - base), DW'(32));

        // 5a: start mid-sweep ignored
        push_scaled(1);
        base = accepts;
        do_start();
        wait_accepts(base, 10);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(24'd256);
        chk("t5_accepts", DW'(accepts - base), DW'(32));

        // 5b: async reset at beat 20
        push_scaled(1);
        base = accepts;
        do_start();
        wait_accepts(base, 20);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", DW'(out_valid), DW'(0));
        chk("rst_mid_lock", DW'(hist_lock), DW'(0));
        chk("rst_mid_addr", DW'(hist_addr), DW'(0));
        exp_q.delete();
        tot_q.delete();
        repeat (3) @(negedge clk);
        chk("rst_mid_done", DW'(done_cnt), DW'(exp_done));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 5c: clean sweep after reset, ramp pattern
        for (int j = 0; j < BINS; j++) mem[j] = 16'(j);
        push_tri();
        base = accepts;
        do_start();
        wait_done(24'd32640);
        chk("t5c_accepts", DW'(accepts - base), DW'(32));

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
